// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg : shared video-pipeline widths and constants               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package video_pkg;
  localparam int LB_ADDR_W  = 10;
  localparam int PIX_W      = 8;
  localparam int LINE_W     = 10;
  localparam int LB_WIDTH   = 640;
  localparam int UNDERRUN_W = 8;
  localparam logic [PIX_W-1:0] PIX_TRANSPARENT = 8'h00;
endpackage
`default_nettype wire

// File: rtl/layer_linebuf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | layer_linebuf_if : renderer-side fill stream of the layer line buffer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface layer_linebuf_if #(
  parameter int DATA_W = video_pkg::PIX_W
);
  logic                         wr_valid;
  logic [DATA_W-1:0]            wr_data;
  logic                         wr_ready;
  logic                         render_start;
  logic [video_pkg::LINE_W-1:0] render_line;

  // Renderer side: drives pixels, learns which line to render.
  modport master (
    output wr_valid, wr_data,
    input  wr_ready, render_start, render_line
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, render_start, render_line
  );
endinterface
`default_nettype wire

// File: rtl/linebuf_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linebuf_dpram : simple dual-port RAM, bank bit is the address MSB    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module linebuf_dpram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [ADDR_W:0]   wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic [ADDR_W:0]   rd_addr,
  output logic      [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Contents are deliberately not reset; the owner gates stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/layer_linebuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | layer_linebuf : ping-pong line buffer, renderer fills / composer reads|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module layer_linebuf
  import video_pkg::*;
#(
  parameter int WIDTH  = LB_WIDTH,
  parameter int ADDR_W = LB_ADDR_W,
  parameter int DATA_W = PIX_W
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  enabled,
  input  wire logic                  start_of_screen,
  input  wire logic                  start_of_line,
  input  wire logic [ADDR_W-1:0]     lb_idx,
  output logic      [DATA_W-1:0]     lb_data,
  output logic      [UNDERRUN_W-1:0] underrun_cnt,
  layer_linebuf_if.slave             wr
);
  localparam logic [ADDR_W:0]     WIDTH_C = (ADDR_W + 1)'(WIDTH);
  localparam logic [UNDERRUN_W-1:0] UR_MAX = '1;

  logic                    rd_bank_q, rd_bank_d;
  logic                    wr_bank;
  logic [ADDR_W:0]         wr_count_q, wr_count_d;
  logic [1:0][ADDR_W:0]    valid_len_q, valid_len_d;
  logic                    filling_q, filling_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    render_start_q, render_start_d;
  logic [LINE_W-1:0]       render_line_q, render_line_d;
  logic [UNDERRUN_W-1:0]   underrun_q, underrun_d;
  logic                    rd_ok_q, rd_ok_d;
  logic                    handshake;
  logic [ADDR_W:0]         wr_total;
  logic [DATA_W-1:0]       ram_rd_data;

  assign wr_bank = ~rd_bank_q;

  always_comb begin
    handshake      = wr.wr_valid & wr_ready_q;
    wr_total       = wr_count_q + (ADDR_W + 1)'(handshake);
    rd_bank_d      = rd_bank_q;
    wr_count_d     = wr_total;
    valid_len_d    = valid_len_q;
    filling_d      = filling_q & enabled;
    render_start_d = 1'b0;
    underrun_d     = underrun_q;
    render_line_d  = render_line_q;

    // A handshake in the swap cycle still belongs to the outgoing bank.
    if (start_of_line) begin
      valid_len_d[wr_bank] = wr_total;
      rd_bank_d            = ~rd_bank_q;
      wr_count_d           = '0;
      filling_d            = enabled;
      render_start_d       = enabled;
      if (filling_q && (wr_total < WIDTH_C) && (underrun_q != UR_MAX)) begin
        underrun_d = underrun_q + UNDERRUN_W'(1);
      end
    end

    if (start_of_screen) begin
      render_line_d = '0;
    end else if (start_of_line) begin
      render_line_d = render_line_q + LINE_W'(1);
    end

    wr_ready_d = filling_d & enabled & (wr_count_d < WIDTH_C) & ~start_of_line;
    rd_ok_d    = enabled & ({1'b0, lb_idx} < valid_len_q[rd_bank_q])
                         & ({1'b0, lb_idx} < WIDTH_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q      <= 1'b0;
      wr_count_q     <= '0;
      valid_len_q    <= '0;
      filling_q      <= 1'b0;
      wr_ready_q     <= 1'b0;
      render_start_q <= 1'b0;
      render_line_q  <= '0;
      underrun_q     <= '0;
      rd_ok_q        <= 1'b0;
    end else begin
      rd_bank_q      <= rd_bank_d;
      wr_count_q     <= wr_count_d;
      valid_len_q    <= valid_len_d;
      filling_q      <= filling_d;
      wr_ready_q     <= wr_ready_d;
      render_start_q <= render_start_d;
      render_line_q  <= render_line_d;
      underrun_q     <= underrun_d;
      rd_ok_q        <= rd_ok_d;
    end
  end

  linebuf_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (handshake),
    .wr_addr ({wr_bank, wr_count_q[ADDR_W-1:0]}),
    .wr_data (wr.wr_data),
    .rd_addr ({rd_bank_q, lb_idx}),
    .rd_data (ram_rd_data)
  );

  // Gate flag was registered with the RAM read, so both describe the same index.
  assign lb_data         = rd_ok_q ? ram_rd_data : DATA_W'(PIX_TRANSPARENT);
  assign underrun_cnt    = underrun_q;
  assign wr.wr_ready     = wr_ready_q;
  assign wr.render_start = render_start_q;
  assign wr.render_line  = render_line_q;
endmodule
`default_nettype wire

// File: tb/tb_layer_linebuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_layer_linebuf : randomized directed bench with reference model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_layer_linebuf;
  localparam int W = 640;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, sos, sol;
  logic [9:0] idx;
  logic [7:0] lb_data;
  logic [7:0] uc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: two banks as plain arrays plus line bookkeeping.
  logic [7:0] m_mem [2][1024];
  int m_len [2];
  int m_rd, m_cnt, m_line, m_uc;
  bit m_fill, m_ready, m_rs;
  logic [7:0] m_lb;

  always #5 clk = ~clk;

  layer_linebuf_if wif ();

  layer_linebuf u_dut (
    .clk             (clk),
    .rst             (rst),
    .enabled         (en),
    .start_of_screen (sos),
    .start_of_line   (sol),
    .lb_idx          (idx),
    .lb_data         (lb_data),
    .underrun_cnt    (uc),
    .wr              (wif.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_len[0] = 0; m_len[1] = 0;
    m_rd = 0; m_cnt = 0; m_line = 0; m_uc = 0;
    m_fill = 0; m_ready = 0; m_rs = 0; m_lb = 8'h00;
  endtask

  // One clock: predict from the rules, clock the DUT, compare every output.
  task automatic cycle();
    int hs, tot;
    logic [7:0] exp_lb;
    hs     = (wif.wr_valid && m_ready) ? 1 : 0;
    tot    = m_cnt + hs;
    exp_lb = (en && int'(idx) < m_len[m_rd] && int'(idx) < W) ? m_mem[m_rd][idx] : 8'h00;
    if (hs != 0) m_mem[1 - m_rd][m_cnt] = wif.wr_data;
    if (sol) begin
      m_len[1 - m_rd] = tot;
      if (m_fill && tot < W && m_uc < 255) m_uc++;
      m_rd   = 1 - m_rd;
      m_cnt  = 0;
      m_fill = en;
      m_rs   = en;
    end else begin
      m_cnt  = tot;
      m_fill = m_fill && en;
      m_rs   = 0;
    end
    if (sos)      m_line = 0;
    else if (sol) m_line = (m_line + 1) % 1024;
    m_ready = m_fill && en && (m_cnt < W) && !sol;
    m_lb    = exp_lb;
    @(posedge clk);
    #1;
    check("lb_data",      lb_data,          m_lb);
    check("wr_ready",     wif.wr_ready,     m_ready);
    check("render_start", wif.render_start, m_rs);
    check("render_line",  wif.render_line,  m_line);
    check("underrun_cnt", uc,               m_uc);
    @(negedge clk);
  endtask

  task automatic fill(input int n, input bit pat);
    int budget = 0;
    while (m_cnt < n && budget < 8 * n + 50) begin
      wif.wr_valid = ($urandom_range(0, 3) != 0);
      wif.wr_data  = pat ? (8'(m_cnt) | 8'h01) : 8'($urandom);
      idx          = 10'($urandom_range(0, 1023));
      cycle();
      budget++;
    end
    wif.wr_valid = 1'b0;
    if (m_cnt < n) begin
      n_tests++;
      n_fail++;
      $error("FAIL fill_timeout observed=%0d expected=%0d", m_cnt, n);
    end
  endtask

  task automatic swap();
    sol = 1'b1;
    cycle();
    sol = 1'b0;
  endtask

  task automatic read_at(input int i);
    idx = 10'(i);
    cycle();
  endtask

  initial begin
    logic [7:0] px;
    rst = 1'b0; en = 1'b0; sos = 1'b0; sol = 1'b0; idx = '0;
    wif.wr_valid = 1'b0; wif.wr_data = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_lb_data",  lb_data,          0);
    check("rst_wr_ready", wif.wr_ready,     0);
    check("rst_rstart",   wif.render_start, 0);
    check("rst_line",     wif.render_line,  0);
    check("rst_underrun", uc,               0);
    rst = 1'b0;

    // 1: first line start
    en = 1'b1;
    swap();
    check("t1_render_start", wif.render_start, 1);
    check("t1_render_line",  wif.render_line,  1);
    cycle();
    check("t1_wr_ready",     wif.wr_ready,     1);
    check("t1_rstart_pulse", wif.render_start, 0);

    // 2: full line with idx|1 pattern
    fill(W, 1'b1);
    check("t2_ready_drop", wif.wr_ready, 0);
    wif.wr_valid = 1'b1;
    repeat (3) cycle();
    wif.wr_valid = 1'b0;
    swap();
    read_at(5);
    check("t2_px5", lb_data, 8'h05);
    check("t2_no_underrun", uc, 0);

    // 3: short line
    fill(100, 1'b0);
    repeat (4) cycle();
    px = m_mem[1 - m_rd][99];
    swap();
    check("t3_underrun", uc, 1);
    read_at(99);
    check("t3_px99", lb_data, px);
    read_at(100);
    check("t3_px100", lb_data, 0);
    read_at(700);
    check("t3_px700", lb_data, 0);

    // 4: last pixel handshakes in the swap cycle
    fill(639, 1'b0);
    wif.wr_valid = 1'b1; wif.wr_data = 8'hA5;
    swap();
    wif.wr_valid = 1'b0;
    read_at(639);
    check("t4_px639", lb_data, 8'hA5);
    check("t4_no_underrun", uc, 1);

    // 5: start_of_screen with and without start_of_line
    fill(30, 1'b0);
    sos = 1'b1;
    swap();
    sos = 1'b0;
    check("t5_line_sos_sol", wif.render_line, 0);
    read_at(29);
    fill(50, 1'b0);
    sos = 1'b1;
    cycle();
    sos = 1'b0;
    check("t5_line_sos", wif.render_line, 0);
    fill(100, 1'b0);
    px = m_mem[1 - m_rd][75];
    swap();
    read_at(75);
    check("t5_px75", lb_data, px);
    read_at(100);
    check("t5_px100", lb_data, 0);

    // 6: asynchronous reset mid-fill
    fill(200, 1'b0);
    read_at(10);
    #2 rst = 1'b1;
    #1;
    check("t6_lb_data",  lb_data,          0);
    check("t6_wr_ready", wif.wr_ready,     0);
    check("t6_rstart",   wif.render_start, 0);
    check("t6_line",     wif.render_line,  0);
    check("t6_underrun", uc,               0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wif.wr_valid = 1'b1;
      read_at(i * 37);
    end
    wif.wr_valid = 1'b0;
    swap();
    for (int i = 0; i < 10; i++) read_at(i * 61);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en           = ($urandom_range(0, 15) != 0);
      sol          = ($urandom_range(0, 199) == 0);
      sos          = ($urandom_range(0, 999) == 0);
      wif.wr_valid = ($urandom_range(0, 3) != 0);
      wif.wr_data  = 8'($urandom);
      idx          = 10'($urandom_range(0, 1023));
      cycle();
    end
    sol = 1'b0; sos = 1'b0; wif.wr_valid = 1'b0;

    // Underrun counter saturation
    en = 1'b1;
    swap();
    for (int i = 0; i < 262; i++) begin
      swap();
      cycle();
    end
    check("sat_underrun", uc, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
